// File: rtl/data_out_encoder_pkg.sv
// Shared types and width helpers for the byte-lane word encoder.
package data_out_encoder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam int unsigned BYTE_W = 8;

    // Number of byte lanes in a word of the given width.
    function automatic int unsigned lanes_of(input int unsigned bits);
        return bits / BYTE_W;
    endfunction

    // Width of a lane index for the given lane count (never narrower than 1).
    function automatic int unsigned lane_w_of(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/data_out_encoder_byte_parity.sv
// Even parity of one byte: 1 when the byte holds an odd number of ones.
module data_out_encoder_byte_parity (
    input  logic [7:0] data,
    output logic       par
);

    assign par = ^data;

endmodule

// File: rtl/data_out_encoder.sv
// Serializes a BITS-wide word into bytes, lane 0 first, each tagged with its lane index.
// Optional even-parity output out_par is built when DATA_OUT_PARITY_EN is defined.
module data_out_encoder
    import data_out_encoder_pkg::*;
#(
    parameter int unsigned BITS = 32
) (
    input  logic                                  wb_clk_i,
    input  logic                                  wb_rst_i,
    input  logic [BITS-1:0]                       in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [7:0]                            out_data,
    output logic [lane_w_of(lanes_of(BITS))-1:0]  out_sel,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_last,
    output logic                                  busy
`ifdef DATA_OUT_PARITY_EN
   ,output logic                                  out_par
`endif
);

    localparam int unsigned LANES  = lanes_of(BITS);
    localparam int unsigned LANE_W = lane_w_of(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    state_t            state, state_n;
    logic [BITS-1:0]   word_q, word_n;
    logic [LANE_W-1:0] lane_q, lane_n;
    logic [7:0]        byte_n;
    logic              hs;

    // Next-state, next-word and next-lane selection; in_ready is the only combinational output.
    always_comb begin
        state_n  = state;
        word_n   = word_q;
        lane_n   = lane_q;
        hs       = out_valid & out_ready;
        in_ready = (state == ST_IDLE) | (out_last & out_ready);
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    word_n  = in_data;
                    lane_n  = '0;
                    state_n = ST_SEND;
                end
            end
            ST_SEND: begin
                if (hs) begin
                    if (lane_q != LAST_LANE) begin
                        lane_n = lane_q + LANE_W'(1);
                    end else if (in_valid) begin
                        word_n = in_data;
                        lane_n = '0;
                    end else begin
                        state_n = ST_IDLE;
                        lane_n  = '0;
                    end
                end
            end
        endcase
        byte_n = (state_n == ST_SEND) ? 8'(word_n >> {lane_n, 3'b000}) : 8'h00;
    end

    // State, word and lane registers plus the registered output view of the next byte.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            word_q    <= '0;
            lane_q    <= '0;
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            word_q    <= word_n;
            lane_q    <= lane_n;
            out_data  <= byte_n;
            out_sel   <= lane_n;
            out_valid <= (state_n == ST_SEND);
            out_last  <= (state_n == ST_SEND) && (lane_n == LAST_LANE);
            busy      <= (state_n == ST_SEND);
        end
    end

`ifdef DATA_OUT_PARITY_EN
    logic par_n;

    data_out_encoder_byte_parity u_byte_parity (
        .data (byte_n),
        .par  (par_n)
    );

    // Parity is registered alongside out_data so it stays aligned under backpressure.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_par <= 1'b0;
        end else begin
            out_par <= par_n;
        end
    end
`endif

endmodule

// File: tb/tb_data_out_encoder.sv
// Randomized and directed checks of data_out_encoder against a byte-queue reference model.
module tb_data_out_encoder;

    localparam int unsigned BITS  = 32;
    localparam int unsigned LANES = BITS / 8;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] s;
    } lane_byte_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [BITS-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       out_data;
    logic [1:0]       out_sel;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
`ifdef DATA_OUT_PARITY_EN
    logic             out_par;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    lane_byte_t q[$];
    bit         model_ok = 0;
    logic [7:0] seen[$];

    always #5 clk = ~clk;

    data_out_encoder #(.BITS(BITS)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
`ifdef DATA_OUT_PARITY_EN
       ,.out_par   (out_par)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs after the falling edge, compare against the model, then advance the model.
    task automatic step(input logic iv, input logic [31:0] d, input logic ord, input logic r);
        logic       e_valid;
        logic [7:0] e_data;
        logic [1:0] e_sel;
        logic       e_ready;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ord;
        rst       = r;
        #1;
        e_valid = (q.size() > 0);
        e_data  = e_valid ? q[0].d : 8'h00;
        e_sel   = e_valid ? q[0].s : 2'd0;
        e_ready = (q.size() == 0) || (q.size() == 1 && ord);
        if (model_ok) begin
            check("out_valid", 32'(out_valid), 32'(e_valid));
            check("out_data",  32'(out_data),  32'(e_data));
            check("out_sel",   32'(out_sel),   32'(e_sel));
            check("out_last",  32'(out_last),  32'(e_valid && e_sel == 2'(LANES - 1)));
            check("busy",      32'(busy),      32'(e_valid));
            check("in_ready",  32'(in_ready),  32'(e_ready));
`ifdef DATA_OUT_PARITY_EN
            check("out_par",   32'(out_par),   32'(^e_data));
`endif
        end
        if (out_valid === 1'b1 && ord && !r) seen.push_back(out_data);
        @(posedge clk);
        if (r) begin
            q.delete();
            model_ok = 1;
        end else if (model_ok) begin
            if (e_valid && ord) void'(q.pop_front());
            if (iv && e_ready) begin
                for (int i = 0; i < LANES; i++) begin
                    q.push_back('{d: 8'(d >> (8 * i)), s: 2'(i)});
                end
            end
        end
    endtask

    task automatic expect_seen(input string tag, input logic [31:0] w0, input logic [31:0] w1, input int nw);
        logic [31:0] words[2];
        words[0] = w0;
        words[1] = w1;
        check({tag, "_count"}, 32'(seen.size()), 32'(nw * LANES));
        for (int i = 0; i < nw * LANES && i < seen.size(); i++) begin
            check(tag, 32'(seen[i]), 32'(8'(words[i / LANES] >> (8 * (i % LANES)))));
        end
        seen.delete();
    endtask

    initial begin
        in_valid  = 0;
        in_data   = '0;
        out_ready = 0;
        rst       = 1;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Reset state
        step(0, 0, 1, 0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);

        // Mid-word reset drops the word
        step(1, 32'h55667788, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_sel",   32'(out_sel), 32'd0);
        check("rst_mid_busy",  32'(busy), 32'd0);
        check("rst_mid_ready", 32'(in_ready), 32'd1);
        seen.delete();

        // Single word
        step(1, 32'hA1B2C3D4, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        expect_seen("single", 32'hA1B2C3D4, 0, 1);
        check("single_idle", 32'(busy), 32'd0);

        // Backpressure on lane 1
        step(1, 32'h11223344, 1, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        expect_seen("bp", 32'h11223344, 0, 1);

        // Back-to-back with in_valid held
        step(1, 32'hDEADBEEF, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 32'h01020304, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        expect_seen("b2b", 32'hDEADBEEF, 32'h01020304, 2);

        // Ignored input while busy
        step(1, 32'hCAFEF00D, 1, 0);
        step(1, 32'hFFFFFFFF, 1, 0);
        step(0, 0, 1, 0);
        step(1, 32'hFFFFFFFF, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        expect_seen("ignored", 32'hCAFEF00D, 0, 1);

`ifdef DATA_OUT_PARITY_EN
        // Parity on known bytes 00,01,03,80
        step(1, 32'h80030100, 1, 0);
        step(0, 0, 1, 0); check("par_00", 32'(out_par), 32'd0);
        step(0, 0, 1, 0); check("par_01", 32'(out_par), 32'd1);
        step(0, 0, 1, 0); check("par_03", 32'(out_par), 32'd0);
        step(0, 0, 1, 0); check("par_80", 32'(out_par), 32'd1);
        step(0, 0, 1, 0);
        seen.delete();
`endif

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 199) == 0));
        end
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
        check("drain_empty", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
